// File: rtl/cyborg65r2_pkg.sv
// Shared types and constants for the cyborg65r2 measurement sequencer.
package cyborg65r2_pkg;

  localparam int ENC_W   = 12;  // encoder count / frame delta width
  localparam int ENC_LAT = 8;   // warm-up cycles after the encoder leaves reset
  localparam int FLEN_W  = 16;  // width of cfg_frame_len
  localparam int NFR_W   = 8;   // width of cfg_num_frames
  localparam int WARM_W  = $clog2(ENC_LAT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WARMUP  = 2'd1,
    MEASURE = 2'd2,
    DRAIN   = 2'd3
  } state_t;

endpackage

// File: rtl/cyborg65r2_res_fifo.sv
// Two-entry result FIFO on the falling clock edge. Entry 0 is always the head,
// so the read port is a plain register. A push that finds the FIFO full with no
// pop on the same edge is discarded and flagged on drop for that cycle.
module cyborg65r2_res_fifo #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         resetb,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         drop
);

  logic [W-1:0] slot0_q, slot0_d;
  logic [W-1:0] slot1_q, slot1_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         full;
  logic         pop_eff;
  logic         push_ok;

  assign empty = (cnt_q == 2'd0);
  assign full  = (cnt_q == 2'd2);
  assign rdata = slot0_q;

  // Next-state of the storage: flush wins, otherwise pop shifts and push appends.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    cnt_d   = cnt_q;
    pop_eff = pop && !empty;
    push_ok = push && (!full || pop_eff);
    drop    = push && !flush && !push_ok;
    if (flush) begin
      cnt_d = 2'd0;
    end else begin
      if (pop_eff) begin
        slot0_d = slot1_q;
      end
      if (push_ok) begin
        if (empty || ((cnt_q == 2'd1) && pop_eff)) begin
          slot0_d = wdata;
        end else begin
          slot1_d = wdata;
        end
      end
      case ({pop_eff, push_ok})
        2'b10:   cnt_d = cnt_q - 2'd1;
        2'b01:   cnt_d = cnt_q + 2'd1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Storage registers, updated on the encoder's falling edge.
  always_ff @(negedge clk or negedge resetb) begin
    if (!resetb) begin
      slot0_q <= '0;
      slot1_q <= '0;
      cnt_q   <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/cyborg65r2_meas_ctrl.sv
// Measurement sequencer for the cyborg65r2 CCO time encoder. Keeps the encoder
// in reset while idle, skips its warm-up samples after release, then slices the
// free-running count into frames of flen cycles and queues one modular delta per
// frame for the readout.
//
// Result handshake: res_valid is high whenever the result FIFO holds an entry and
// res_data is then the oldest entry; the consumer takes it on a falling edge where
// res_valid && res_ready, and res_data must not be assumed stable otherwise.
module cyborg65r2_meas_ctrl
  import cyborg65r2_pkg::*;
(
  input  logic              clk,
  input  logic              resetb,
  input  logic              start,
  input  logic              abort,
  input  logic [FLEN_W-1:0] cfg_frame_len,
  input  logic [NFR_W-1:0]  cfg_num_frames,
  output logic              enc_resetb,
  input  logic [ENC_W-1:0]  enc_count,
  output logic [ENC_W-1:0]  res_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output state_t            dbg_state
);

  state_t            state_q, state_d;
  logic [WARM_W-1:0] warm_q, warm_d;
  logic [FLEN_W-1:0] flen_q, flen_d;
  logic [FLEN_W-1:0] fcnt_q, fcnt_d;
  logic [NFR_W-1:0]  nfr_cfg_q, nfr_cfg_d;
  logic [NFR_W-1:0]  nfr_q, nfr_d;
  logic [ENC_W-1:0]  base_q, base_d;
  logic              enc_resetb_q, enc_resetb_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;

  logic              start_acc;
  logic              push;
  logic              flush;
  logic [ENC_W-1:0]  delta;
  logic              fifo_empty;
  logic              fifo_drop;

  // Modular difference: a frame that crosses the 2^ENC_W wrap still yields its true increase.
  assign delta = enc_count - base_q;

  // Sequencer next-state, frame counters and registered-output targets.
  always_comb begin
    state_d   = state_q;
    warm_d    = warm_q;
    flen_d    = flen_q;
    fcnt_d    = fcnt_q;
    nfr_cfg_d = nfr_cfg_q;
    nfr_d     = nfr_q;
    base_d    = base_q;
    done_d    = 1'b0;
    start_acc = 1'b0;
    push      = 1'b0;
    flush     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          start_acc = 1'b1;
          flen_d    = (cfg_frame_len == '0) ? FLEN_W'(1) : cfg_frame_len;
          nfr_cfg_d = cfg_num_frames;
          nfr_d     = '0;
          warm_d    = WARM_W'(ENC_LAT);
          state_d   = WARMUP;
        end
      end
      WARMUP: begin
        if (warm_q == '0) begin
          base_d  = enc_count;
          fcnt_d  = flen_q - FLEN_W'(1);
          state_d = MEASURE;
        end else begin
          warm_d = warm_q - WARM_W'(1);
        end
      end
      MEASURE: begin
        if (fcnt_q == '0) begin
          // Frame boundary: the closing sample is also the next frame's base, so no cycle is lost.
          push   = 1'b1;
          base_d = enc_count;
          fcnt_d = flen_q - FLEN_W'(1);
          nfr_d  = nfr_q + NFR_W'(1);
          if ((nfr_cfg_q != '0) && (nfr_d == nfr_cfg_q)) begin
            state_d = DRAIN;
          end
        end else begin
          fcnt_d = fcnt_q - FLEN_W'(1);
        end
      end
      DRAIN: begin
        if (fifo_empty) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d   = IDLE;
      flush     = 1'b1;
      push      = 1'b0;
      done_d    = 1'b0;
      start_acc = 1'b0;
    end
    enc_resetb_d = (state_d == WARMUP) || (state_d == MEASURE);
    busy_d       = (state_d != IDLE);
  end

  // Sticky overflow: cleared when a measurement is accepted, set by any dropped result.
  always_comb begin
    ovf_d = ovf_q;
    if (start_acc) begin
      ovf_d = 1'b0;
    end
    if (fifo_drop) begin
      ovf_d = 1'b1;
    end
  end

  // Sequencer state and registered outputs, on the encoder's falling edge.
  always_ff @(negedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q      <= IDLE;
      warm_q       <= '0;
      flen_q       <= FLEN_W'(1);
      fcnt_q       <= '0;
      nfr_cfg_q    <= '0;
      nfr_q        <= '0;
      base_q       <= '0;
      enc_resetb_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      warm_q       <= warm_d;
      flen_q       <= flen_d;
      fcnt_q       <= fcnt_d;
      nfr_cfg_q    <= nfr_cfg_d;
      nfr_q        <= nfr_d;
      base_q       <= base_d;
      enc_resetb_q <= enc_resetb_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      ovf_q        <= ovf_d;
    end
  end

  cyborg65r2_res_fifo #(
    .W (ENC_W)
  ) u_res_fifo (
    .clk    (clk),
    .resetb (resetb),
    .flush  (flush),
    .push   (push),
    .wdata  (delta),
    .pop    (res_ready),
    .rdata  (res_data),
    .empty  (fifo_empty),
    .drop   (fifo_drop)
  );

  assign res_valid  = !fifo_empty;
  assign enc_resetb = enc_resetb_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign ovf        = ovf_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_cyborg65r2_meas_ctrl.sv
// Directed bench for cyborg65r2_meas_ctrl. Inputs change 1 time unit after each
// falling edge; outputs are read there or on the rising edge in between.
module tb_cyborg65r2_meas_ctrl;
  import cyborg65r2_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b1;
  always #5 clk = ~clk;

  logic              resetb;
  logic              start;
  logic              abort;
  logic [FLEN_W-1:0] cfg_frame_len;
  logic [NFR_W-1:0]  cfg_num_frames;
  logic              enc_resetb;
  logic [ENC_W-1:0]  enc_count;
  logic [ENC_W-1:0]  res_data;
  logic              res_valid;
  logic              res_ready;
  logic              busy;
  logic              done;
  logic              ovf;
  state_t            dbg_state;

  int n_vec    = 0;
  int n_bad    = 0;
  int rate     = 0;
  int done_cnt = 0;
  logic sb_en  = 1'b0;
  logic [ENC_W-1:0] exp_q[$];

  cyborg65r2_meas_ctrl dut (
    .clk            (clk),
    .resetb         (resetb),
    .start          (start),
    .abort          (abort),
    .cfg_frame_len  (cfg_frame_len),
    .cfg_num_frames (cfg_num_frames),
    .enc_resetb     (enc_resetb),
    .enc_count      (enc_count),
    .res_data       (res_data),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .busy           (busy),
    .done           (done),
    .ovf            (ovf),
    .dbg_state      (dbg_state)
  );

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock: scoreboard pops and done pulses are observed mid-cycle, then the
  // falling edge passes and the encoder model advances by rate.
  task automatic step();
    @(posedge clk);
    if (done) done_cnt++;
    if (sb_en && res_valid && res_ready) begin
      chk("sb_expected_pending", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("sb_res_data", 32'(res_data), 32'(exp_q.pop_front()));
    end
    @(negedge clk);
    #1;
    enc_count = enc_count + 12'(rate);
  endtask

  task automatic start_meas(input int flen, input int nfr, input int r);
    cfg_frame_len  = 16'(flen);
    cfg_num_frames = 8'(nfr);
    rate           = r;
    start          = 1'b1;
    step();
    start          = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      step();
      k++;
    end
    chk(tag, 32'(busy), 0);
  endtask

  // flen=10, nfr=3, +5/cycle, consumer always ready: three deltas of 50.
  task automatic run_s1();
    int d0;
    exp_q.delete();
    repeat (3) exp_q.push_back(12'd50);
    sb_en     = 1'b1;
    res_ready = 1'b1;
    d0        = done_cnt;
    start_meas(10, 3, 5);
    chk("s1_busy", 32'(busy), 1);
    chk("s1_enc_released", 32'(enc_resetb), 1);
    chk("s1_no_early_done", 32'(done), 0);
    wait_idle("s1_timeout", 200);
    chk("s1_done_at_idle", 32'(done), 1);
    chk("s1_all_results", exp_q.size(), 0);
    chk("s1_enc_held", 32'(enc_resetb), 0);
    chk("s1_no_ovf", 32'(ovf), 0);
    step();
    chk("s1_done_one_cycle", 32'(done), 0);
    chk("s1_done_count", done_cnt - d0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d0;
    resetb         = 1'b0;
    start          = 1'b0;
    abort          = 1'b0;
    res_ready      = 1'b0;
    cfg_frame_len  = '0;
    cfg_num_frames = '0;
    enc_count      = '0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_enc_resetb", 32'(enc_resetb), 0);
    chk("rst_res_data", 32'(res_data), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ovf", 32'(ovf), 0);
    resetb = 1'b1;
    step();

    // Scenario 1: basic three-frame measurement.
    run_s1();

    // Scenario 2: base captured at 4090, frame ends at 6 after the wrap -> 12.
    exp_q.delete();
    sb_en     = 1'b1;
    res_ready = 1'b0;
    enc_count = 12'd4063;
    start_meas(4, 1, 3);
    for (int k = 2; k <= 13; k++) step();
    chk("s2_not_yet_valid", 32'(res_valid), 0);
    step();
    chk("s2_valid", 32'(res_valid), 1);
    chk("s2_wrap_delta", 32'(res_data), 12);
    chk("s2_no_ovf", 32'(ovf), 0);
    exp_q.push_back(12'd12);
    res_ready = 1'b1;
    wait_idle("s2_timeout", 20);
    chk("s2_done", 32'(done), 1);
    chk("s2_all_results", exp_q.size(), 0);

    // Scenario 3: consumer stalled, four frames of 2 then 8,8,8; last two dropped.
    exp_q.delete();
    sb_en     = 1'b1;
    res_ready = 1'b0;
    enc_count = '0;
    start_meas(2, 4, 1);
    for (int k = 2; k <= 20; k++) begin
      rate = (k <= 11) ? 1 : 4;
      step();
      if (k == 15) chk("s3_no_ovf_yet", 32'(ovf), 0);
    end
    chk("s3_ovf", 32'(ovf), 1);
    chk("s3_held_valid", 32'(res_valid), 1);
    chk("s3_head_first", 32'(res_data), 2);
    chk("s3_waiting_drain", 32'(busy), 1);
    exp_q.push_back(12'd2);
    exp_q.push_back(12'd8);
    res_ready = 1'b1;
    wait_idle("s3_timeout", 20);
    chk("s3_done", 32'(done), 1);
    chk("s3_all_results", exp_q.size(), 0);
    chk("s3_ovf_sticky", 32'(ovf), 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("s3_ovf_held_abort", 32'(ovf), 1);

    // Scenario 4: abort two cycles into MEASURE with one result queued.
    exp_q.delete();
    sb_en     = 1'b1;
    res_ready = 1'b0;
    start_meas(2, 0, 3);
    chk("s4_start_clears_ovf", 32'(ovf), 0);
    for (int k = 2; k <= 12; k++) step();
    chk("s4_one_queued", 32'(res_valid), 1);
    chk("s4_queued_delta", 32'(res_data), 6);
    d0    = done_cnt;
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("s4_busy", 32'(busy), 0);
    chk("s4_flushed", 32'(res_valid), 0);
    chk("s4_enc_held", 32'(enc_resetb), 0);
    chk("s4_no_done", 32'(done), 0);
    res_ready = 1'b1;
    step();
    step();
    chk("s4_no_done_later", done_cnt - d0, 0);
    chk("s4_still_empty", 32'(res_valid), 0);

    // Scenario 5: continuous mode, flen 0 acts as 1, +7/cycle; mid-run start ignored.
    sb_en     = 1'b0;
    res_ready = 1'b1;
    start_meas(0, 0, 7);
    for (int k = 2; k <= 30; k++) begin
      if (k == 20) start = 1'b1;
      step();
      start = 1'b0;
      if (k >= 11) begin
        chk("s5_valid", 32'(res_valid), 1);
        chk("s5_delta", 32'(res_data), 7);
      end
    end
    chk("s5_still_busy", 32'(busy), 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("s5_abort_busy", 32'(busy), 0);
    chk("s5_abort_valid", 32'(res_valid), 0);
    chk("s5_abort_enc", 32'(enc_resetb), 0);

    // Scenario 6: asynchronous reset mid-measurement, then a fresh scenario 1.
    sb_en     = 1'b0;
    res_ready = 1'b1;
    start_meas(10, 3, 5);
    for (int k = 2; k <= 22; k++) step();
    chk("s6_pre_busy", 32'(busy), 1);
    #2;
    resetb = 1'b0;
    #1;
    chk("s6_enc_resetb", 32'(enc_resetb), 0);
    chk("s6_res_data", 32'(res_data), 0);
    chk("s6_res_valid", 32'(res_valid), 0);
    chk("s6_busy", 32'(busy), 0);
    chk("s6_done", 32'(done), 0);
    chk("s6_ovf", 32'(ovf), 0);
    @(negedge clk);
    #1;
    resetb = 1'b1;
    step();
    run_s1();

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
